// File: rtl/sorter_pkg.sv
// Shared Sorter definitions: default geometry, lane extraction helper and the
// streamer FSM state type.
package sorter_pkg;

  localparam int DEF_LANES = 8;
  localparam int DEF_W     = 8;
  localparam int IDX_W     = $clog2(DEF_LANES);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic logic [DEF_W-1:0] lane(input logic [DEF_LANES*DEF_W-1:0] word,
                                            input int unsigned i);
    return word[i*DEF_W +: DEF_W];
  endfunction

endpackage

// File: rtl/lane_order_checker.sv
// Combinational monotonic-order check of a packed word: sorted=1 when every
// lane is unsigned <= the next higher lane.
module lane_order_checker
  import sorter_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int W     = DEF_W
) (
  input  logic [LANES*W-1:0] word,
  output logic               sorted
);

  logic [LANES-2:0] pair_ok;

  generate
    for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_cmp
      assign pair_ok[gi] = (word[gi*W +: W] <= word[(gi+1)*W +: W]);
    end
  endgenerate

  assign sorted = &pair_ok;

endmodule

// File: rtl/sorted_word_streamer.sv
// Accepts packed sorted words into an active/pending double buffer and streams
// them one lane per transfer; optionally counts words that arrive out of order.
module sorted_word_streamer
  import sorter_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int W        = DEF_W,
  parameter int DESCEND  = 0,
  parameter int CHECK_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*W-1:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(LANES)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       order_err,
  output logic [7:0]                 err_cnt
);

  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] FIRST_IDX = (DESCEND != 0) ? IW'(LANES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX  = (DESCEND != 0) ? '0 : IW'(LANES - 1);

  state_t              state_reg, state_next;
  logic [LANES*W-1:0]  active_reg, pend_reg;
  logic                pend_full_reg, alive_reg;
  logic [IW-1:0]       idx_reg, idx_next;
  logic                load_in, load_pend, pend_wr, pend_clr;
  logic                accept, xfer, last_xfer;
  logic [W-1:0]        active_lanes [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign active_lanes[gi] = active_reg[gi*W +: W];
    end
  endgenerate

  // alive_reg keeps in_ready low until the first clock after reset release
  assign in_ready  = alive_reg & ~pend_full_reg;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == STREAM);
  assign out_idx   = idx_reg;
  assign out_data  = active_lanes[idx_reg];
  assign out_last  = out_valid & (idx_reg == LAST_IDX);
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & out_last;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    pend_wr    = 1'b0;
    pend_clr   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend_full_reg) begin
          load_pend  = 1'b1;
          pend_clr   = 1'b1;
          idx_next   = FIRST_IDX;
          state_next = STREAM;
        end else if (accept) begin
          load_in    = 1'b1;
          idx_next   = FIRST_IDX;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          // refill from pending first; a same-edge accept only bypasses when pending is empty
          if (pend_full_reg) begin
            load_pend = 1'b1;
            pend_clr  = 1'b1;
            idx_next  = FIRST_IDX;
          end else if (accept) begin
            load_in  = 1'b1;
            idx_next = FIRST_IDX;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (xfer) idx_next = (DESCEND != 0) ? idx_reg - 1'b1 : idx_reg + 1'b1;
          if (accept) pend_wr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      active_reg    <= '0;
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      alive_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      alive_reg <= 1'b1;
      if (load_in)        active_reg <= in_data;
      else if (load_pend) active_reg <= pend_reg;
      if (pend_wr) begin
        pend_reg      <= in_data;
        pend_full_reg <= 1'b1;
      end else if (pend_clr) begin
        pend_full_reg <= 1'b0;
      end
    end
  end

  generate
    if (CHECK_EN != 0) begin : g_chk
      logic       sorted;
      logic       err_reg;
      logic [7:0] cnt_reg;

      lane_order_checker #(.LANES(LANES), .W(W)) u_checker (
        .word   (in_data),
        .sorted (sorted)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          err_reg <= accept & ~sorted;
          if (accept && !sorted && cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
        end
      end

      assign order_err = err_reg;
      assign err_cnt   = cnt_reg;
    end else begin : g_nochk
      assign order_err = 1'b0;
      assign err_cnt   = '0;
    end
  endgenerate

endmodule

// File: tb/tb_sorted_word_streamer.sv
// Bench: ascending and descending instances share stimulus; a queue-based word
// model predicts every output each cycle, plus literal checks on directed cases.
module tb_sorted_word_streamer;
  import sorter_pkg::*;

  localparam int L  = DEF_LANES;
  localparam int WW = DEF_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [L*WW-1:0] in_data = '0;

  logic            in_ready_a, out_valid_a, out_last_a, order_err_a;
  logic [WW-1:0]   out_data_a;
  logic [IDX_W-1:0] out_idx_a;
  logic [7:0]      err_cnt_a;
  logic            in_ready_b, out_valid_b, out_last_b, order_err_b;
  logic [WW-1:0]   out_data_b;
  logic [IDX_W-1:0] out_idx_b;
  logic [7:0]      err_cnt_b;

  sorted_word_streamer #(.LANES(L), .W(WW), .DESCEND(0), .CHECK_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_idx(out_idx_a),
    .out_last(out_last_a), .order_err(order_err_a), .err_cnt(err_cnt_a)
  );

  sorted_word_streamer #(.LANES(L), .W(WW), .DESCEND(1), .CHECK_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_idx(out_idx_b),
    .out_last(out_last_b), .order_err(order_err_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [L*WW-1:0] mq[$];
  int  pos_m   = 0;
  bit  alive_m = 0;
  bit  perr_m  = 0;
  int  errc_m  = 0;

  function automatic bit is_sorted(input logic [L*WW-1:0] w);
    for (int i = 0; i < L - 1; i++)
      if (lane(w, i) > lane(w, i + 1)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pos_m   = 0;
      alive_m = 0;
      perr_m  = 0;
      errc_m  = 0;
    end else begin
      bit ov, ir, xf, ac;
      ov = (mq.size() > 0);
      ir = alive_m && (mq.size() < 2);
      xf = ov && out_ready;
      ac = in_valid && ir;
      perr_m = 0;
      if (xf) begin
        pos_m++;
        if (pos_m == L) begin
          void'(mq.pop_front());
          pos_m = 0;
        end
      end
      if (ac) begin
        mq.push_back(in_data);
        if (!is_sorted(in_data)) begin
          perr_m = 1;
          if (errc_m < 255) errc_m++;
        end
      end
      alive_m = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit ov;
    ov = (mq.size() > 0);
    chk("in_ready_a", in_ready_a, alive_m && mq.size() < 2);
    chk("in_ready_b", in_ready_b, alive_m && mq.size() < 2);
    chk("out_valid_a", out_valid_a, ov);
    chk("out_valid_b", out_valid_b, ov);
    if (ov) begin
      chk("out_data_a", out_data_a, lane(mq[0], pos_m));
      chk("out_data_b", out_data_b, lane(mq[0], L - 1 - pos_m));
      chk("out_idx_a", out_idx_a, pos_m);
      chk("out_idx_b", out_idx_b, L - 1 - pos_m);
      chk("out_last_a", out_last_a, pos_m == L - 1);
      chk("out_last_b", out_last_b, pos_m == L - 1);
    end
    chk("order_err_a", order_err_a, perr_m);
    chk("order_err_b", order_err_b, perr_m);
    chk("err_cnt_a", err_cnt_a, errc_m);
    chk("err_cnt_b", err_cnt_b, errc_m);
  end

  // lanes actually transferred, for literal sequence checks
  logic [WW-1:0] got_a[$];
  logic [WW-1:0] got_b[$];
  always @(posedge clk) begin
    if (rst_n && out_valid_a && out_ready) got_a.push_back(out_data_a);
    if (rst_n && out_valid_b && out_ready) got_b.push_back(out_data_b);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [L*WW-1:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready_a && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) fail_now("send_accept");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input int idx);
    int t;
    t = 0;
    while (!(out_valid_a && out_idx_a == idx) && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) fail_now("wait_idx");
  endtask

  function automatic logic [L*WW-1:0] rand_sorted();
    logic [L*WW-1:0] w;
    int v;
    v = $urandom_range(0, 60);
    for (int i = 0; i < L; i++) begin
      v = v + $urandom_range(0, 30);
      if (v > 255) v = 255;
      w[i*WW +: WW] = WW'(v);
    end
    return w;
  endfunction

  logic [L*WW-1:0] w2, w3, w_uns, w_eq;
  logic [WW-1:0]   exp_asc [L];

  initial begin
    w2    = 64'hF0C8_8040_2010_0801;
    w3    = 64'h7766_5544_3322_1100;
    w_uns = 64'h0102_0304_0506_0807;
    w_eq  = 64'h5555_5555_5555_5555;
    exp_asc = '{8'h01, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hC8, 8'hF0};

    // reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready_a, 1'b0);
    chk("rst_out_idx_b", out_idx_b, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready_a, 1'b1);

    // reset mid-stream at lane 3
    out_ready = 1'b1;
    send(w2);
    wait_idx(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid_a", out_valid_a, 1'b0);
    chk("midrst_out_valid_b", out_valid_b, 1'b0);
    chk("midrst_err_cnt", err_cnt_a, 0);
    chk("midrst_out_data", out_data_a, 0);
    tick();
    rst_n = 1'b1;
    got_a.delete();
    tick();
    chk("midrst_in_ready", in_ready_a, 1'b1);
    repeat (10) tick();
    chk("no_stale_lanes", got_a.size(), 0);

    // single word, ascending and descending order
    got_a.delete();
    got_b.delete();
    send(w2);
    chk("first_lane_latency", out_data_a, 8'h01);
    repeat (10) tick();
    chk("asc_count", got_a.size(), L);
    chk("desc_count", got_b.size(), L);
    for (int i = 0; i < L; i++) begin
      if (i < got_a.size()) chk($sformatf("asc_lane%0d", i), got_a[i], exp_asc[i]);
      if (i < got_b.size()) chk($sformatf("desc_lane%0d", i), got_b[i], exp_asc[L-1-i]);
    end

    // stall at lane 2
    send(w2);
    wait_idx(2);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_data", out_data_a, 8'h10);
      chk("stall_idx", out_idx_a, 2);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_idx", out_idx_a, 3);
    repeat (10) tick();

    // back-to-back words with pending full
    got_a.delete();
    send(w2);
    send(w3);
    chk("pend_full_in_ready", in_ready_a, 1'b0);
    repeat (15) tick();
    chk("b2b_lanes", got_a.size(), 2 * L);
    if (got_a.size() > L) chk("b2b_second_first", got_a[L], 8'h00);
    send(rand_sorted());
    repeat (12) tick();

    // unsorted words and counter saturation
    send(w_uns);
    chk("uns_pulse", order_err_a, 1'b1);
    chk("uns_cnt", err_cnt_a, 1);
    for (int k = 0; k < 300; k++) send(w_uns);
    repeat (20) tick();
    chk("sat_cnt", err_cnt_a, 255);
    send(w_eq);
    chk("equal_no_pulse", order_err_a, 1'b0);
    chk("equal_cnt", err_cnt_a, 255);
    repeat (12) tick();

    // randomized traffic with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) != 0) in_data = rand_sorted();
      else in_data = {$urandom(), $urandom()};
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) tick();
    chk("drained", out_valid_a, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
